// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined carry-lookahead adder/subtractor, one 16-bit
// CLA slice per stage, inter-slice carry registered between stages.
//   clk, rst        : clock, asynchronous active-high reset
//   in_valid, a, b  : operation request (two's complement operands)
//   cin, sub        : carry-in, subtract (b inverted, carry-in inverted)
//   sat_en          : clamp result on signed overflow
//   out_valid, s    : registered result, NS = WIDTH/16 cycles after input
//   cout, ovf       : raw MSB carry-out, signed overflow
//   pg, gg          : group propagate / generate over the full width

// 16-bit two-level CLA: 4-bit groups, lookahead across groups.
module cla_pipe_addsub_cla16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_c,
  output logic [15:0] o_s,
  output logic        o_p,
  output logic        o_g
);
  logic [15:0] w_p, w_g, w_c;
  logic [3:0]  w_gp, w_gg, w_gc;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  always_comb begin
    w_gp = '0;
    w_gg = '0;
    for (int j = 0; j < 4; j++) begin
      w_gp[j] = &w_p[4*j +: 4];
      w_gg[j] = w_g[4*j+3] | (w_p[4*j+3] & w_g[4*j+2])
              | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
              | ((&w_p[4*j+1 +: 3]) & w_g[4*j]);
    end
  end

  // group carries fully expanded from the slice carry-in
  assign w_gc[0] = i_c;
  assign w_gc[1] = w_gg[0] | (w_gp[0] & i_c);
  assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_c);
  assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[2] & w_gp[1] & w_gp[0] & i_c);

  always_comb begin
    w_c = '0;
    for (int j = 0; j < 4; j++) begin
      w_c[4*j] = w_gc[j];
      for (int i = 1; i < 4; i++)
        w_c[4*j+i] = w_g[4*j+i-1] | (w_p[4*j+i-1] & w_c[4*j+i-1]);
    end
  end

  assign o_s = w_p ^ w_c;
  assign o_p = &w_gp;
  assign o_g = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
             | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0]);
endmodule

module cla_pipe_addsub #(
  parameter int WIDTH       = 32,
  parameter bit SAT_DEFAULT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             sat_en,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             pg,
  output logic             gg
);
  localparam int NS = WIDTH / 16;

  logic [WIDTH-1:0] w_bx;
  logic             w_c0;
  logic             r_vo, r_cout, r_ovf, r_pg, r_gg;
  logic [WIDTH-1:0] r_s;

  assign w_bx = sub ? ~b : b;
  assign w_c0 = cin ^ sub;

  // Stage k: w_ra/w_rb hold the operand slices not yet added (slice k at
  // the bottom), w_full holds result slices 0..k once slice k is summed.
  for (genvar k = 0; k < NS; k++) begin : g_stg
    logic [WIDTH-16*k-1:0] w_ra, w_rb;
    logic                  w_ci, w_pin, w_gin, w_vin, w_sat;
    logic [15:0]           w_sum;
    logic                  w_p, w_g;
    logic [16*k+15:0]      w_full;

    if (k == 0) begin : g_in
      assign w_ra   = a;
      assign w_rb   = w_bx;
      assign w_ci   = w_c0;
      assign w_pin  = 1'b1;
      assign w_gin  = 1'b0;
      assign w_vin  = in_valid;
      assign w_sat  = sat_en;
      assign w_full = w_sum;
    end else begin : g_in
      assign w_ra   = g_stg[k-1].g_mid.r_a;
      assign w_rb   = g_stg[k-1].g_mid.r_b;
      assign w_ci   = g_stg[k-1].g_mid.r_c;
      assign w_pin  = g_stg[k-1].g_mid.r_p;
      assign w_gin  = g_stg[k-1].g_mid.r_g;
      assign w_vin  = g_stg[k-1].g_mid.r_v;
      assign w_sat  = g_stg[k-1].g_mid.r_sat;
      assign w_full = {w_sum, g_stg[k-1].g_mid.r_sum};
    end

    cla_pipe_addsub_cla16 u_cla (
      .i_a (w_ra[15:0]),
      .i_b (w_rb[15:0]),
      .i_c (w_ci),
      .o_s (w_sum),
      .o_p (w_p),
      .o_g (w_g)
    );

    if (k < NS-1) begin : g_mid
      logic [WIDTH-16*k-17:0] r_a, r_b;
      logic [16*k+15:0]       r_sum;
      logic                   r_c, r_p, r_g, r_v, r_sat;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_v   <= 1'b0;
          r_a   <= '0;
          r_b   <= '0;
          r_sum <= '0;
          r_c   <= 1'b0;
          r_p   <= 1'b0;
          r_g   <= 1'b0;
          r_sat <= SAT_DEFAULT;
        end else begin
          r_v   <= w_vin;
          r_a   <= w_ra[WIDTH-16*k-1:16];
          r_b   <= w_rb[WIDTH-16*k-1:16];
          r_sum <= w_full;
          r_c   <= w_g | (w_p & w_ci);
          // running group P/G, composed without the carry-in
          r_p   <= w_pin & w_p;
          r_g   <= w_g | (w_p & w_gin);
          r_sat <= w_sat;
        end
      end
    end else begin : g_last
      logic w_ovf;
      // top slice holds the sign bits: same operand signs, different sum sign
      assign w_ovf = (w_ra[15] == w_rb[15]) && (w_sum[15] != w_ra[15]);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vo   <= 1'b0;
          r_s    <= '0;
          r_cout <= 1'b0;
          r_ovf  <= 1'b0;
          r_pg   <= 1'b0;
          r_gg   <= 1'b0;
        end else begin
          r_vo   <= w_vin;
          r_s    <= (w_sat && w_ovf) ? {w_ra[15], {(WIDTH-1){~w_ra[15]}}} : w_full;
          r_cout <= w_g | (w_p & w_ci);
          r_ovf  <= w_ovf;
          r_pg   <= w_pin & w_p;
          r_gg   <= w_g | (w_p & w_gin);
        end
      end
    end
  end

  assign out_valid = r_vo;
  assign s         = r_s;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign pg        = r_pg;
  assign gg        = r_gg;
endmodule
